// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch-side producer for the instruction decoder. Fetches one 32-bit word at
// a time from the instruction bus, tracks the byte PC and presents one
// instruction slot per beat as {instr, halfWordSelector, instrPC}.
//   - Long words (bit 31 set) occupy a whole word and must sit at PC[1]=0.
//   - Short words are presented twice (lower half, then upper half) from the
//     same fetched word, unless the upper half is a NOP (bits 30:16 all zero),
//     in which case the upper half is skipped.
//   - A redirect restarts fetching at a new PC. A fetch already on the bus is
//     completed and its data thrown away.
// There is no prefetch: a new word is only requested once the last slot of
// the current word has been accepted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   memReq/memAddr      fetch request and word address, held until memAck
//   memAck/memData      one-cycle response pulse with the fetched word
//   instrValid          a beat is presented on instr/halfWordSelector/instrPC
//   decodeReady         decoder accepts the presented beat
//   instr               fetched word, passed whole
//   halfWordSelector    0 = short half [15:0], 1 = short half [31:16]
//   instrPC             byte PC of the presented slot
//   redirect/redirectPC load a new PC (bit 0 forced to 0)
//   alignFault          one-cycle pulse: long word found at PC[1]=1
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic        instrValid,
  input  logic        decodeReady,
  output logic [31:0] instr,
  output logic        halfWordSelector,
  output logic [31:0] instrPC,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        alignFault
);

  typedef enum logic [2:0] {
    FETCH_ISSUE,
    FETCH_WAIT,
    PRESENT,
    DISCARD,
    FAULT
  } state_t;

  localparam logic [31:0] PC_INIT   = RESET_PC & 32'hFFFF_FFFE;
  localparam logic [31:0] ADDR_INIT = RESET_PC & 32'hFFFF_FFFC;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_addr;
  logic [31:0] w_addr_nxt;
  logic [31:0] r_word;
  logic [31:0] w_word_nxt;

  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_word;
  logic        w_long;
  logic        w_upper_live;
  logic        w_misaligned;

  assign w_redir_pc   = redirectPC & 32'hFFFF_FFFE;
  assign w_pc_word    = r_pc & 32'hFFFF_FFFC;
  assign w_long       = r_word[31];
  // A short word whose upper 15 bits are zero carries a NOP in its upper half.
  assign w_upper_live = |r_word[30:16];
  assign w_misaligned = w_long & r_pc[1];

  assign instr   = r_word;
  assign instrPC = r_pc;

  // State, PC and fetch-address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_ISSUE;
      r_pc    <= PC_INIT;
      r_addr  <= ADDR_INIT;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_word  <= w_word_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr;
    w_word_nxt       = r_word;
    memReq           = 1'b0;
    memAddr          = r_addr;
    instrValid       = 1'b0;
    halfWordSelector = 1'b0;
    alignFault       = 1'b0;

    case (r_state)
      FETCH_ISSUE: begin
        // Request goes out combinationally from the current PC; it is held
        // low while rst is asserted so nothing leaves the block in reset.
        memReq      = ~rst;
        memAddr     = w_pc_word;
        w_addr_nxt  = w_pc_word;
        w_state_nxt = FETCH_WAIT;
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = FETCH_ISSUE;
        end
      end

      FETCH_WAIT: begin
        memReq = 1'b1;
        if (redirect) begin
          // The bus transaction cannot be withdrawn: finish it in DISCARD
          // unless it completes right now, then refetch from the new PC.
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = memAck ? FETCH_ISSUE : DISCARD;
        end else if (memAck) begin
          w_word_nxt  = memData;
          w_state_nxt = PRESENT;
        end
      end

      PRESENT: begin
        if (w_misaligned) begin
          alignFault  = 1'b1;
          w_state_nxt = FAULT;
        end else begin
          instrValid       = 1'b1;
          halfWordSelector = r_pc[1];
          if (decodeReady) begin
            if (!w_long && !r_pc[1] && w_upper_live) begin
              // Lower half of a short word: upper half follows from the
              // same fetched word, no refetch.
              w_pc_nxt = r_pc + 32'd2;
            end else if (r_pc[1]) begin
              w_pc_nxt    = r_pc + 32'd2;
              w_state_nxt = FETCH_ISSUE;
            end else begin
              // Long word, or short word with a NOP upper half.
              w_pc_nxt    = r_pc + 32'd4;
              w_state_nxt = FETCH_ISSUE;
            end
          end
        end
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = FETCH_ISSUE;
        end
      end

      DISCARD: begin
        memReq = 1'b1;
        if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end
        if (memAck) begin
          w_state_nxt = FETCH_ISSUE;
        end
      end

      FAULT: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = FETCH_ISSUE;
        end
      end

      default: begin
        w_state_nxt = FETCH_ISSUE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Scoreboard bench for instr_fetch_unit. A memory model answers fetches with
// random latency from a 64-word array (indexed by addr[7:2]). Whenever the
// stimulus redirects or resets the fetcher, the expected beat stream from the
// new PC is computed from the instruction-format rules and queued; a monitor
// pops and compares every accepted beat and every alignment fault.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        instrValid;
  logic        decodeReady;
  logic [31:0] instr;
  logic        halfWordSelector;
  logic [31:0] instrPC;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        alignFault;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .memReq           (memReq),
    .memAddr          (memAddr),
    .memAck           (memAck),
    .memData          (memData),
    .instrValid       (instrValid),
    .decodeReady      (decodeReady),
    .instr            (instr),
    .halfWordSelector (halfWordSelector),
    .instrPC          (instrPC),
    .redirect         (redirect),
    .redirectPC       (redirectPC),
    .alignFault       (alignFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    logic [31:0] instr;
    bit          hw;
    logic [31:0] pc;
  } exp_t;

  logic [31:0] mem [64];
  exp_t        q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_beats  = 0;
  int n_acks   = 0;
  int n_faults = 0;
  bit mem_hold = 1'b0;
  int mem_lat_force = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
  endtask

  // Expected beat stream starting at a PC, straight from the format rules.
  task automatic expect_from(input logic [31:0] start);
    logic [31:0] pc;
    logic [31:0] w;
    exp_t        e;
    pc = start & 32'hFFFF_FFFE;
    q.delete();
    for (int k = 0; k < 512; k++) begin
      w       = mem[pc[7:2]];
      e.fault = 1'b0;
      e.instr = w;
      e.pc    = pc;
      e.hw    = pc[1];
      if (w[31] && pc[1]) begin
        e.fault = 1'b1;
        q.push_back(e);
        break;
      end
      q.push_back(e);
      if (w[31])                pc = pc + 32'd4;
      else if (pc[1])           pc = pc + 32'd2;
      else if (w[30:16] != 0)   pc = pc + 32'd2;
      else                      pc = pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r | 32'h8000_0000;
      1:       return {1'b0, (r[30:16] == 15'h0) ? 15'h1 : r[30:16], r[15:0]};
      default: return {16'h0, r[15:0]};
    endcase
  endfunction

  // Memory: sees a request mid-cycle, answers 1..3 cycles later with the
  // word at the address on the bus in the ack cycle.
  initial begin
    int lat;
    memAck  = 1'b0;
    memData = '0;
    forever begin
      @(negedge clk);
      #3;
      if (memReq && !mem_hold && !rst) begin
        lat = (mem_lat_force >= 0) ? mem_lat_force : int'($urandom_range(0, 2));
        repeat (lat + 1) @(posedge clk);
        #1;
        memAck  = 1'b1;
        memData = mem[memAddr[7:2]];
        n_acks++;
        @(posedge clk);
        #1;
        memAck  = 1'b0;
        memData = $urandom;
      end
    end
  end

  // Monitor: samples one time unit before each rising edge.
  initial begin
    bit          ps;
    logic [31:0] ps_instr;
    logic [31:0] ps_pc;
    logic        ps_hw;
    exp_t        e;
    ps = 1'b0;
    ps_instr = '0;
    ps_pc = '0;
    ps_hw = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          chk("stall_valid_hw", {30'd0, instrValid, halfWordSelector}, {30'd0, 1'b1, ps_hw});
          chk("stall_instr", instr, ps_instr);
          chk("stall_pc", instrPC, ps_pc);
        end
        ps       = instrValid && !decodeReady && !redirect;
        ps_instr = instr;
        ps_pc    = instrPC;
        ps_hw    = halfWordSelector;

        if (alignFault && !redirect) begin
          n_faults++;
          chk("fault_valid_low", 32'(instrValid), 32'd0);
          if (q.size() == 0) begin
            chk("fault_queue_nonempty", 32'd0, 32'd1);
          end else begin
            e = q.pop_front();
            chk("fault_expected", 32'(e.fault), 32'd1);
          end
        end

        if (instrValid && decodeReady && !redirect) begin
          n_beats++;
          if (q.size() == 0) begin
            chk("beat_queue_nonempty", instrPC, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("beat_kind", 32'(e.fault), 32'd0);
            chk("beat_instr", instr, e.instr);
            chk("beat_hw", 32'(halfWordSelector), 32'(e.hw));
            chk("beat_pc", instrPC, e.pc);
          end
        end
      end
    end
  end

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst      = 1'b1;
    redirect = 1'b0;
    q.delete();
    repeat (cyc) @(negedge clk);
    #4;
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memAddr", memAddr, RESET_PC & 32'hFFFF_FFFC);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_hw", 32'(halfWordSelector), 32'd0);
    chk("rst_pc", instrPC, RESET_PC & 32'hFFFF_FFFE);
    chk("rst_fault", 32'(alignFault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_from(RESET_PC);
  endtask

  task automatic wait_beats(input int target, input string name);
    for (int k = 0; k < 200 && n_beats < target; k++) @(negedge clk);
    chk(name, 32'(n_beats >= target), 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] addr, input string name);
    for (int k = 0; k < 200 && !memReq; k++) @(negedge clk);
    chk(name, {memReq, memAddr[30:0]}, {1'b1, addr[30:0]});
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge clk);
    redirect   = 1'b1;
    redirectPC = pc;
    expect_from(pc);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  initial begin
    int a0;
    int b0;
    int f0;
    logic [31:0] t;
    rst         = 1'b1;
    decodeReady = 1'b1;
    redirect    = 1'b0;
    redirectPC  = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Long word at 0
    mem[0] = 32'h8000_0001;
    mem[1] = 32'h8000_0002;
    do_reset(6);
    a0 = n_acks;
    b0 = n_beats;
    wait_beats(b0 + 1, "A_beat_seen");
    wait_req(32'h4, "A_next_addr");
    chk("A_one_fetch", 32'(n_acks - a0), 32'd1);

    // Short word with live upper half: two beats, one fetch
    mem[0] = 32'h1234_0567;
    mem[1] = 32'h8000_0003;
    do_reset(6);
    a0 = n_acks;
    b0 = n_beats;
    wait_beats(b0 + 2, "B_two_beats");
    chk("B_one_fetch", 32'(n_acks - a0), 32'd1);
    wait_req(32'h4, "B_next_addr");

    // Short word with NOP upper half: single beat
    mem[0] = 32'h0000_1111;
    mem[1] = 32'h8000_0004;
    do_reset(6);
    a0 = n_acks;
    b0 = n_beats;
    wait_beats(b0 + 1, "C_beat_seen");
    chk("C_one_fetch", 32'(n_acks - a0), 32'd1);
    wait_req(32'h4, "C_next_addr");

    // Decoder stall for three cycles
    mem[0] = 32'h0ABC_1234;
    decodeReady = 1'b0;
    do_reset(6);
    for (int k = 0; k < 100 && !instrValid; k++) @(negedge clk);
    chk("D_valid", 32'(instrValid), 32'd1);
    b0 = n_beats;
    repeat (3) @(negedge clk);
    chk("D_no_accept_while_stalled", 32'(n_beats - b0), 32'd0);
    decodeReady = 1'b1;
    wait_beats(b0 + 2, "D_released");

    // Redirect while waiting on the bus at address 8
    mem[2]  = 32'h8000_0008;
    mem[16] = 32'h8000_0040;
    @(negedge clk);
    rst      = 1'b1;
    mem_hold = 1'b1;
    q.delete();
    repeat (6) @(negedge clk);
    rst        = 1'b0;
    redirect   = 1'b1;
    redirectPC = 32'h8;
    expect_from(32'h8);
    @(negedge clk);
    redirect      = 1'b0;
    mem_hold      = 1'b0;
    mem_lat_force = 4;
    @(negedge clk);
    redirect   = 1'b1;
    redirectPC = 32'h40;
    expect_from(32'h40);
    a0 = n_acks;
    b0 = n_beats;
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 0; k < 20 && n_acks == a0; k++) begin
      chk("E_hold_req", 32'(memReq), 32'd1);
      chk("E_hold_addr", memAddr, 32'h8);
      @(negedge clk);
    end
    mem_lat_force = -1;
    chk("E_old_ack", 32'(n_acks - a0), 32'd1);
    @(negedge clk);
    chk("E_new_req", {memReq, memAddr[30:0]}, {1'b1, 31'h40});
    wait_beats(b0 + 1, "E_beat_seen");

    // Long word at a PC with bit 1 set
    mem[1] = 32'h9000_0000;
    mem[4] = 32'h8000_0010;
    f0 = n_faults;
    b0 = n_beats;
    do_redirect(32'h6);
    for (int k = 0; k < 50 && n_faults == f0; k++) @(negedge clk);
    chk("F_fault_seen", 32'(n_faults - f0), 32'd1);
    repeat (5) @(negedge clk);
    chk("F_single_pulse", 32'(n_faults - f0), 32'd1);
    chk("F_valid_low", 32'(instrValid), 32'd0);
    chk("F_req_low", 32'(memReq), 32'd0);
    chk("F_no_beat", 32'(n_beats - b0), 32'd0);
    do_redirect(32'h10);
    wait_beats(b0 + 1, "F_resume");

    // PC wrap at the top of the address space (odd target, bit 0 dropped)
    mem[63] = 32'h8000_00FC;
    mem[0]  = 32'h8000_0111;
    b0 = n_beats;
    do_redirect(32'hFFFF_FFFD);
    wait_beats(b0 + 2, "G_wrap_beats");

    // Random traffic
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    do_reset(6);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      decodeReady = ($urandom_range(0, 3) != 0);
      if (rst) begin
        rst = 1'b0;
        expect_from(RESET_PC);
      end else if ($urandom_range(0, 799) == 0) begin
        rst      = 1'b1;
        redirect = 1'b0;
        q.delete();
      end else if ($urandom_range(0, 19) == 0) begin
        t = $urandom_range(0, 255);
        if ($urandom_range(0, 7) == 0) t = t | 32'hFFFF_FF00;
        redirect   = 1'b1;
        redirectPC = t;
        expect_from(t);
      end else begin
        redirect = 1'b0;
      end
    end
    @(negedge clk);
    redirect = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
